// File: rtl/i2si_bist_pkg.sv
// Shared definitions for the I2S input BIST pattern generator: waveform mode
// encodings, LFSR taps and the sequencer state type.
package i2si_bist_pkg;

    localparam logic [1:0] BIST_SAW   = 2'd0;
    localparam logic [1:0] BIST_TRI   = 2'd1;
    localparam logic [1:0] BIST_CONST = 2'd2;
    localparam logic [1:0] BIST_LFSR  = 2'd3;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } bist_state_t;

    // One right-shift Galois step; the all-zero lock-up state is escaped to 1.
    function automatic logic [15:0] lfsr_step(input logic [15:0] state);
        logic [15:0] nxt;
        nxt = {1'b0, state[15:1]} ^ (state[0] ? LFSR_TAPS : 16'h0000);
        if (nxt == 16'h0000) begin
            nxt = 16'h0001;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/i2si_bist_wave.sv
// Waveform state for the BIST generator: holds the current sample value and
// triangle direction, and steps them on a frame-end advance strobe.
module i2si_bist_wave
    import i2si_bist_pkg::*;
#(
    parameter int SAMPLE_W = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                advance,
    input  logic [1:0]          mode,
    input  logic [SAMPLE_W-1:0] start_val,
    input  logic [SAMPLE_W-1:0] up_limit,
    input  logic [7:0]          inc,
    output logic [SAMPLE_W-1:0] value
);

    logic [SAMPLE_W-1:0] value_reg, value_next;
    logic                dir_down_reg, dir_down_next;
    logic [1:0]          mode_reg, mode_next;

    logic [SAMPLE_W:0]   v_ext, s_ext, u_ext, i_ext, sum, diff;
    logic [SAMPLE_W-1:0] tri_up_val, tri_dn_val;
    logic                dir_down_eff;
    logic                inverted;

    always_comb begin
        v_ext = {1'b0, value_reg};
        s_ext = {1'b0, start_val};
        u_ext = {1'b0, up_limit};
        i_ext = (SAMPLE_W+1)'(inc);
        sum   = v_ext + i_ext;
        diff  = v_ext - i_ext;

        tri_up_val = (sum > u_ext) ? up_limit : sum[SAMPLE_W-1:0];
        tri_dn_val = (diff[SAMPLE_W] || (diff < s_ext)) ? start_val : diff[SAMPLE_W-1:0];

        inverted = (start_val > up_limit);
        // Switching modes restarts the triangle on its rising leg.
        dir_down_eff = dir_down_reg && (mode == mode_reg);

        value_next    = value_reg;
        dir_down_next = dir_down_reg;
        mode_next     = mode_reg;

        if (load) begin
            value_next    = ((mode == BIST_LFSR) && (start_val == '0)) ? SAMPLE_W'(1) : start_val;
            dir_down_next = 1'b0;
            mode_next     = mode;
        end else if (advance) begin
            mode_next     = mode;
            dir_down_next = dir_down_eff;
            case (mode)
                BIST_SAW: begin
                    if (inverted || (value_reg >= up_limit) || sum[SAMPLE_W]) begin
                        value_next = start_val;
                    end else begin
                        value_next = sum[SAMPLE_W-1:0];
                    end
                end
                BIST_TRI: begin
                    if (inverted) begin
                        value_next = start_val;
                    end else if (!dir_down_eff) begin
                        if (value_reg >= up_limit) begin
                            dir_down_next = 1'b1;
                            value_next    = tri_dn_val;
                        end else begin
                            value_next = tri_up_val;
                        end
                    end else begin
                        if (value_reg <= start_val) begin
                            dir_down_next = 1'b0;
                            value_next    = tri_up_val;
                        end else begin
                            value_next = tri_dn_val;
                        end
                    end
                end
                BIST_CONST: value_next = start_val;
                default:    value_next = SAMPLE_W'(lfsr_step(value_reg[15:0]));
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_reg    <= '0;
            dir_down_reg <= 1'b0;
            mode_reg     <= BIST_SAW;
        end else begin
            value_reg    <= value_next;
            dir_down_reg <= dir_down_next;
            mode_reg     <= mode_next;
        end
    end

    assign value = value_reg;

endmodule

// File: rtl/i2si_bist_gen_mc.sv
// Multi-channel BIST sample source for the I2S input path: slot timing from SCK
// edges, channel interleave with masking, and registered sample/xfc outputs.
module i2si_bist_gen_mc
    import i2si_bist_pkg::*;
#(
    parameter  int SAMPLE_W  = 24,
    parameter  int SLOT_BITS = 32,
    parameter  int NUM_CH    = 2,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int SC_W      = $clog2(SLOT_BITS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sck_transition,
    input  logic                rf_bist_en,
    input  logic [1:0]          rf_bist_mode,
    input  logic [SAMPLE_W-1:0] rf_bist_start_val,
    input  logic [SAMPLE_W-1:0] rf_bist_up_limit,
    input  logic [7:0]          rf_bist_inc,
    input  logic [NUM_CH-1:0]   rf_bist_ch_mask,
    output logic [SAMPLE_W-1:0] i2si_bist_out_data,
    output logic [CH_W-1:0]     i2si_bist_out_ch,
    output logic                i2si_bist_out_xfc
);

    localparam logic [SC_W-1:0] SC_MAX = SC_W'(SLOT_BITS - 1);
    localparam logic [CH_W-1:0] CH_MAX = CH_W'(NUM_CH - 1);

    bist_state_t         state_reg, state_next;
    logic [SC_W-1:0]     slot_cnt_reg, slot_cnt_next;
    logic [CH_W-1:0]     ch_reg, ch_next;
    logic [SAMPLE_W-1:0] out_data_reg, out_data_next;
    logic [CH_W-1:0]     out_ch_reg, out_ch_next;
    logic                xfc_reg, xfc_next;

    logic                slot_tick;
    logic                wave_load, wave_adv;
    logic [SAMPLE_W-1:0] wave_value;
    logic [NUM_CH-1:0]   mask_hit;
    logic                ch_masked;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_mask
        assign mask_hit[gi] = rf_bist_ch_mask[gi] && (ch_reg == CH_W'(gi));
    end
    assign ch_masked = |mask_hit;

    assign slot_tick = sck_transition && (slot_cnt_reg == SC_MAX);

    i2si_bist_wave #(
        .SAMPLE_W (SAMPLE_W)
    ) u_wave (
        .clk       (clk),
        .rst       (rst),
        .load      (wave_load),
        .advance   (wave_adv),
        .mode      (rf_bist_mode),
        .start_val (rf_bist_start_val),
        .up_limit  (rf_bist_up_limit),
        .inc       (rf_bist_inc),
        .value     (wave_value)
    );

    always_comb begin
        state_next    = state_reg;
        slot_cnt_next = slot_cnt_reg;
        ch_next       = ch_reg;
        out_data_next = out_data_reg;
        out_ch_next   = out_ch_reg;
        xfc_next      = 1'b0;
        wave_load     = 1'b0;
        wave_adv      = 1'b0;

        // Disable overrides everything, including a coincident slot tick.
        if (!rf_bist_en) begin
            state_next    = IDLE;
            slot_cnt_next = SC_MAX;
            ch_next       = '0;
            out_data_next = '0;
            out_ch_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    slot_cnt_next = SC_MAX;
                    ch_next       = '0;
                    if (slot_tick) begin
                        state_next    = RUN;
                        slot_cnt_next = '0;
                        wave_load     = 1'b1;
                    end
                end
                RUN: begin
                    if (sck_transition) begin
                        slot_cnt_next = (slot_cnt_reg == SC_MAX) ? '0 : slot_cnt_reg + SC_W'(1);
                    end
                    if (slot_tick) begin
                        out_data_next = ch_masked ? '0 : wave_value;
                        out_ch_next   = ch_reg;
                        xfc_next      = 1'b1;
                        if (ch_reg == CH_MAX) begin
                            ch_next  = '0;
                            wave_adv = 1'b1;
                        end else begin
                            ch_next = ch_reg + CH_W'(1);
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            slot_cnt_reg <= SC_MAX;
            ch_reg       <= '0;
            out_data_reg <= '0;
            out_ch_reg   <= '0;
            xfc_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            slot_cnt_reg <= slot_cnt_next;
            ch_reg       <= ch_next;
            out_data_reg <= out_data_next;
            out_ch_reg   <= out_ch_next;
            xfc_reg      <= xfc_next;
        end
    end

    assign i2si_bist_out_data = out_data_reg;
    assign i2si_bist_out_ch   = out_ch_reg;
    assign i2si_bist_out_xfc  = xfc_reg;

endmodule

// File: tb/tb_i2si_bist_gen_mc.sv
// Directed bench for i2si_bist_gen_mc: a default 2-channel instance and a
// 16-bit, 4-channel, short-slot instance, checked against hand-computed values.
module tb_i2si_bist_gen_mc;

    logic clk = 1'b0;
    logic rst;
    logic sck_transition;

    // Instance A: SAMPLE_W=24, SLOT_BITS=32, NUM_CH=2
    logic        en_a;
    logic [1:0]  mode_a;
    logic [23:0] start_a, limit_a;
    logic [7:0]  inc_a;
    logic [1:0]  mask_a;
    logic [23:0] data_a;
    logic [0:0]  ch_a;
    logic        xfc_a;

    // Instance B: SAMPLE_W=16, SLOT_BITS=4, NUM_CH=4
    logic        en_b;
    logic [1:0]  mode_b;
    logic [15:0] start_b, limit_b;
    logic [7:0]  inc_b;
    logic [3:0]  mask_b;
    logic [15:0] data_b;
    logic [1:0]  ch_b;
    logic        xfc_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    i2si_bist_gen_mc dut_a (
        .clk                (clk),
        .rst                (rst),
        .sck_transition     (sck_transition),
        .rf_bist_en         (en_a),
        .rf_bist_mode       (mode_a),
        .rf_bist_start_val  (start_a),
        .rf_bist_up_limit   (limit_a),
        .rf_bist_inc        (inc_a),
        .rf_bist_ch_mask    (mask_a),
        .i2si_bist_out_data (data_a),
        .i2si_bist_out_ch   (ch_a),
        .i2si_bist_out_xfc  (xfc_a)
    );

    i2si_bist_gen_mc #(
        .SAMPLE_W  (16),
        .SLOT_BITS (4),
        .NUM_CH    (4)
    ) dut_b (
        .clk                (clk),
        .rst                (rst),
        .sck_transition     (sck_transition),
        .rf_bist_en         (en_b),
        .rf_bist_mode       (mode_b),
        .rf_bist_start_val  (start_b),
        .rf_bist_up_limit   (limit_b),
        .rf_bist_inc        (inc_b),
        .rf_bist_ch_mask    (mask_b),
        .i2si_bist_out_data (data_b),
        .i2si_bist_out_ch   (ch_b),
        .i2si_bist_out_xfc  (xfc_b)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue nbits SCK edges (1 clk high, 1 clk low each) and record any xfc
    // seen one clk after an edge, plus whether xfc stayed high a second clk.
    task automatic run_slot(input int nbits, input bit sel_b,
                            output logic [31:0] data, output logic [31:0] ch,
                            output int nx, output int pos, output bit wide);
        logic x;
        nx = 0; pos = -1; wide = 1'b0; data = '0; ch = '0;
        for (int k = 0; k < nbits; k++) begin
            @(negedge clk); sck_transition = 1'b1;
            @(posedge clk); #1;
            x = sel_b ? xfc_b : xfc_a;
            if (x) begin
                nx++;
                pos  = k;
                data = sel_b ? 32'(data_b) : 32'(data_a);
                ch   = sel_b ? 32'(ch_b) : 32'(ch_a);
            end
            @(negedge clk); sck_transition = 1'b0;
            @(posedge clk); #1;
            x = sel_b ? xfc_b : xfc_a;
            if (x) wide = 1'b1;
        end
    endtask

    task automatic check_slot(input string tag, input bit sel_b, input int nbits,
                              input logic [31:0] exp_data, input logic [31:0] exp_ch);
        logic [31:0] d, c;
        int nx, pos;
        bit wide;
        run_slot(nbits, sel_b, d, c, nx, pos, wide);
        $display("slot %s: ch=%0d data=%0h xfc_count=%0d", tag, c, d, nx);
        check_val({tag, "_data"}, d, exp_data);
        check_val({tag, "_ch"}, c, exp_ch);
        check_val({tag, "_xfc_timing"}, 32'(nx == 1 && pos == nbits - 1 && !wide), 32'd1);
    endtask

    task automatic expect_no_xfc(input string tag, input int nbits, input bit sel_b);
        logic [31:0] d, c;
        int nx, pos;
        bit wide;
        run_slot(nbits, sel_b, d, c, nx, pos, wide);
        check_val(tag, 32'(nx), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] saw_v [5]  = '{32'd10, 32'd20, 32'd30, 32'd40, 32'd10};
        logic [31:0] tri_v [8]  = '{32'd0, 32'd10, 32'd20, 32'd25, 32'd15, 32'd5, 32'd0, 32'd10};
        logic [31:0] lfsr_v [3] = '{32'h1, 32'hB400, 32'h5A00};
        logic [31:0] d, c, e;
        int nx, pos;
        bit wide;

        rst = 1'b1; sck_transition = 1'b0;
        en_a = 0; mode_a = 0; start_a = 0; limit_a = 0; inc_a = 0; mask_a = 0;
        en_b = 0; mode_b = 0; start_b = 0; limit_b = 0; inc_b = 0; mask_b = 0;

        @(negedge clk);
        check_val("rst_data_a", 32'(data_a), 32'd0);
        check_val("rst_ch_a", 32'(ch_a), 32'd0);
        check_val("rst_xfc_a", 32'(xfc_a), 32'd0);
        check_val("rst_data_b", 32'(data_b), 32'd0);
        rst = 1'b0;

        // Sawtooth: enable tick emits nothing, then 10,20,30,40,10 per frame
        mode_a = 2'd0; start_a = 24'd10; limit_a = 24'd40; inc_a = 8'd10; mask_a = 2'b00;
        en_a = 1'b1;
        expect_no_xfc("saw_enable_no_xfc", 1, 1'b0);
        for (int f = 0; f < 5; f++)
            for (int ch = 0; ch < 2; ch++)
                check_slot("saw", 1'b0, 32, saw_v[f], 32'(ch));

        // Drop enable mid-slot: outputs clear next clk, no further xfc
        run_slot(10, 1'b0, d, c, nx, pos, wide);
        @(negedge clk); en_a = 1'b0;
        @(posedge clk); #1;
        check_val("disable_data", 32'(data_a), 32'd0);
        check_val("disable_ch", 32'(ch_a), 32'd0);
        expect_no_xfc("disable_no_xfc", 40, 1'b0);

        // Re-enable in triangle mode: restarts at start_val on ch0
        mode_a = 2'd1; start_a = 24'd0; limit_a = 24'd25; inc_a = 8'd10;
        en_a = 1'b1;
        expect_no_xfc("tri_enable_no_xfc", 1, 1'b0);
        for (int f = 0; f < 8; f++)
            for (int ch = 0; ch < 2; ch++)
                check_slot("tri", 1'b0, 32, tri_v[f], 32'(ch));

        // Mode written mid-frame only applies at the frame end
        check_slot("premode_ch0", 1'b0, 32, 32'd20, 32'd0);
        mode_a = 2'd2; start_a = 24'd7;
        check_slot("premode_ch1", 1'b0, 32, 32'd20, 32'd1);
        for (int f = 0; f < 2; f++)
            for (int ch = 0; ch < 2; ch++)
                check_slot("const", 1'b0, 32, 32'd7, 32'(ch));

        // Triangle with start above limit holds start_val
        mode_a = 2'd1; start_a = 24'd50; limit_a = 24'd20;
        check_slot("inv_f0_ch0", 1'b0, 32, 32'd7, 32'd0);
        check_slot("inv_f0_ch1", 1'b0, 32, 32'd7, 32'd1);
        for (int f = 0; f < 2; f++)
            for (int ch = 0; ch < 2; ch++)
                check_slot("tri_inv", 1'b0, 32, 32'd50, 32'(ch));

        // Async reset mid-frame, then restart from start_val on ch0
        run_slot(5, 1'b0, d, c, nx, pos, wide);
        #3 rst = 1'b1;
        #1;
        check_val("arst_data", 32'(data_a), 32'd0);
        check_val("arst_ch", 32'(ch_a), 32'd0);
        check_val("arst_xfc", 32'(xfc_a), 32'd0);
        @(negedge clk); rst = 1'b0;
        mode_a = 2'd0; start_a = 24'd60; limit_a = 24'd100; inc_a = 8'd5;
        expect_no_xfc("arst_enable_no_xfc", 1, 1'b0);
        check_slot("arst_restart", 1'b0, 32, 32'd60, 32'd0);
        check_slot("arst_restart", 1'b0, 32, 32'd60, 32'd1);
        check_slot("arst_restart", 1'b0, 32, 32'd65, 32'd0);

        // LFSR with zero seed: 1, B400, 5A00, upper bits zero
        @(negedge clk); en_a = 1'b0;
        @(negedge clk);
        mode_a = 2'd3; start_a = 24'd0; en_a = 1'b1;
        expect_no_xfc("lfsr_enable_no_xfc", 1, 1'b0);
        for (int f = 0; f < 3; f++)
            for (int ch = 0; ch < 2; ch++)
                check_slot("lfsr", 1'b0, 32, lfsr_v[f], 32'(ch));
        @(negedge clk); en_a = 1'b0;

        // 16-bit sawtooth overflow returns to start_val
        mode_b = 2'd0; start_b = 16'hFFF0; limit_b = 16'hFFFF; inc_b = 8'h20; mask_b = 4'b0000;
        en_b = 1'b1;
        expect_no_xfc("ovf_enable_no_xfc", 1, 1'b1);
        for (int f = 0; f < 2; f++)
            for (int ch = 0; ch < 4; ch++)
                check_slot("saw_ovf", 1'b1, 4, 32'hFFF0, 32'(ch));

        // Four channels with ch1/ch3 masked
        @(negedge clk); en_b = 1'b0;
        @(negedge clk);
        start_b = 16'd100; limit_b = 16'd1000; inc_b = 8'd5; mask_b = 4'b1010;
        en_b = 1'b1;
        expect_no_xfc("mask_enable_no_xfc", 1, 1'b1);
        for (int f = 0; f < 2; f++)
            for (int ch = 0; ch < 4; ch++) begin
                e = (ch == 1 || ch == 3) ? 32'd0 : 32'(100 + 5 * f);
                check_slot("mask", 1'b1, 4, e, 32'(ch));
            end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
